switch_entry_ctrl: RTL and testbench
====================================

# switch_entry_ctrl

Input-side counterpart of the board display path. Debounces the four board switches, turns presses into a two-digit decimal entry (0–99), and offers the entered value to the CPU over a valid/ready handshake. The live entry value is also exported in binary so the existing seven-segment driver can show it while the user types.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable clocks needed to accept a switch level. This is 10 ms at 25 MHz. Minimum 2.
- REPEAT_CYCLES, 6250000: auto-repeat interval in clocks. Used only with SWITCH_AUTOREPEAT_EN.

Ports:
- i_Clk, input, 1: system clock.
- i_Rst, input, 1: reset. Asynchronous, active-high.
- i_Switch_1, input, 1: raw switch, high when pressed. Increments the units digit.
- i_Switch_2, input, 1: raw switch, high when pressed. Increments the tens digit.
- i_Switch_3, input, 1: raw switch, high when pressed. Submits the entry.
- i_Switch_4, input, 1: raw switch, high when pressed. Clears the entry.
- o_entry, output, 8: live entry in binary, equal to tens×10 + units.
- o_data, output, 8: submitted value.
- o_valid, output, 1: o_data is offered to the CPU.
- i_ready, input, 1: the CPU accepts o_data.
- o_drop, output, 1: one-cycle pulse when a submit is rejected.

## Operation
- Each switch path:
  - 2-flop synchronizer.
  - Debouncer: a counter that resets whenever the synchronized level equals the stable level. It otherwise increments. When it reaches DEBOUNCE_CYCLES, the stable level flips and the counter clears.
  - Press event: a one-cycle pulse on a 0→1 transition of the stable level. Releases produce no event.
- Digits: units and tens are held as 4-bit BCD values, each 0–9.
  - Increment wraps 9→0.
  - There is no carry from units into tens.
  - o_entry is registered from the digits and has the same timing as the digits.
- Submit event:
  - If o_valid=0: o_data ← entry value as it was before this cycle's digit updates, and o_valid←1.
  - If o_valid=1: no change, and o_drop pulses for one cycle.
- Handshake:
  - Transfer occurs on a cycle where o_valid && i_ready.
  - After a transfer, o_valid drops on the next edge.
  - o_data is held stable while o_valid=1.
  - i_ready while o_valid=0 has no effect.
  - A submit arriving in the same cycle as a transfer is dropped (o_drop pulses). Submit is decided on the registered o_valid.
- Simultaneous events in one cycle:
  - Units and tens events both apply.
  - Clear overrides both increments.
  - Submit captures the pre-update value, then clear or increment applies to the digits.
  - Clear never cancels a pending o_valid.
- Reset (asynchronous): all outputs go to 0. This covers o_entry=0, o_data=0, o_valid=0 and o_drop=0. Synchronizers, stable levels, counters and digits also go to 0. A switch held through reset release yields exactly one press event once it has been debounced.

## Timing
- A raw 0→1 edge held steady produces its press event DEBOUNCE_CYCLES+3 clocks after the first sampling edge. The digit, o_entry, o_valid and o_drop updates occur on the following edge.
- A glitch or bounce shorter than DEBOUNCE_CYCLES produces no event.
- Minimum re-press interval: DEBOUNCE_CYCLES release plus DEBOUNCE_CYCLES press.
- Handshake throughput: at most one transfer per two cycles, since o_valid drops after a transfer and a new submit must follow.

## Configuration
- SWITCH_AUTOREPEAT_EN defined:
  - While the stable level of switch 1 or switch 2 stays high, an extra increment event fires every REPEAT_CYCLES clocks after the press event.
  - One repeat counter is kept per switch and is cleared on release.
  - Switches 3 and 4 never repeat.
- SWITCH_AUTOREPEAT_EN undefined: exactly one event per press. No repeat counters are built, and REPEAT_CYCLES is ignored.

## Structure
- Package switch_entry_pkg holds:
  - BCD digit width (4), DIGIT_MAX (9) and entry width (8).
  - Switch index constants: SW_UNITS=0, SW_TENS=1, SW_SUBMIT=2, SW_CLEAR=3.
- Sub-module switch_debouncer contains the synchronizer, debounce counter, stable level and press pulse. It is parameterized by DEBOUNCE_CYCLES and instantiated four times.
- Digit logic, submit logic, handshake and the optional repeat logic live in the top of the block.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=20.
- Press switch 1 three times, then switch 2 twice, with clean edges → o_entry=23 and o_valid stays 0.
- From units=9, press switch 1 → units=0, tens unchanged, o_entry=tens×10.
- Bounce on switch 1: pulses of 1–3 cycles, then a steady press → exactly one increment.
- Entry=42, press switch 3 with i_ready=0 → o_valid=1 and o_data=42. Then press switch 4 → o_entry=0, o_data still 42. Press switch 3 again → o_drop pulses once. Raise i_ready → o_valid=0 on the next edge.
- Assert i_Rst mid-debounce with o_valid=1 → all outputs are 0 immediately, before any clock edge. Keep switch 1 held through reset release → one increment, o_entry=1.
- With SWITCH_AUTOREPEAT_EN, hold switch 2 for 4+3+1+45 clocks → tens=3, from the press plus 2 repeats.

Source files
------------

// File: rtl/switch_entry_pkg.sv
// switch_entry_pkg: shared widths, switch indices and BCD helper for the switch entry block
package switch_entry_pkg;
  localparam int DIGIT_W = 4;
  localparam int ENTRY_W = 8;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
  localparam int SW_UNITS = 0;
  localparam int SW_TENS = 1;
  localparam int SW_SUBMIT = 2;
  localparam int SW_CLEAR = 3;
  typedef logic [DIGIT_W-1:0] digit_t;
  function automatic digit_t bcd_inc(input digit_t d);
    return (d == DIGIT_MAX) ? '0 : digit_t'(d + 1'b1);
  endfunction
endpackage

// File: rtl/switch_debouncer.sv
// switch_debouncer: 2-flop synchronizer, debounce counter, stable level and press pulse
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_sw,
  output logic o_level,
  output logic o_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic r_stable, r_prev, r_press;
  logic w_flip;
  // the DEBOUNCE_CYCLES-th mismatched edge flips the level instead of storing the count
  assign w_flip = (r_sync[1] != r_stable) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_prev   <= 1'b0;
      r_press  <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], i_sw};
      r_cnt    <= (r_sync[1] == r_stable || w_flip) ? '0 : r_cnt + 1'b1;
      r_stable <= r_stable ^ w_flip;
      r_prev   <= r_stable;
      r_press  <= r_stable & ~r_prev;
    end
  end
  assign o_level = r_stable;
  assign o_press = r_press;
endmodule

// File: rtl/switch_entry_ctrl.sv
// switch_entry_ctrl: debounced switches build a 2-digit BCD entry offered to the CPU via valid/ready
// Optional auto-repeat on the digit switches is enabled by defining SWITCH_AUTOREPEAT_EN.
module switch_entry_ctrl
  import switch_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_CYCLES = 6250000
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Switch_1,
  input  logic               i_Switch_2,
  input  logic               i_Switch_3,
  input  logic               i_Switch_4,
  output logic [ENTRY_W-1:0] o_entry,
  output logic [ENTRY_W-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_drop
);
  logic [3:0] w_sw, w_level, w_press, w_ev;
  logic [1:0] w_rep;
  logic w_inc_u, w_inc_t, w_sub;
  digit_t r_units, r_tens, w_units_n, w_tens_n;
  logic [ENTRY_W-1:0] r_entry, r_data;
  logic r_valid, r_drop;
  assign w_sw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
  genvar i;
  for (i = 0; i < 4; i++) begin : g_db
    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .i_Clk   (i_Clk),
      .i_Rst   (i_Rst),
      .i_sw    (w_sw[i]),
      .o_level (w_level[i]),
      .o_press (w_press[i])
    );
  end
`ifdef SWITCH_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  for (i = 0; i < 2; i++) begin : g_rep
    logic [RW-1:0] r_rep;
    // counting restarts at the press so repeats land every REPEAT_CYCLES after it
    assign w_rep[i] = w_level[i] && !w_press[i] && (r_rep == RW'(REPEAT_CYCLES - 1));
    always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) r_rep <= '0;
      else r_rep <= (!w_level[i] || w_press[i] || w_rep[i]) ? '0 : r_rep + 1'b1;
    end
  end
`else
  assign w_rep = '0;
`endif
  assign w_ev    = w_press & w_level;
  assign w_inc_u = w_ev[SW_UNITS] | w_rep[0];
  assign w_inc_t = w_ev[SW_TENS] | w_rep[1];
  assign w_sub   = w_ev[SW_SUBMIT];
  always_comb begin
    w_units_n = w_ev[SW_CLEAR] ? '0 : w_inc_u ? bcd_inc(r_units) : r_units;
    w_tens_n  = w_ev[SW_CLEAR] ? '0 : w_inc_t ? bcd_inc(r_tens) : r_tens;
  end
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_units <= '0;
      r_tens  <= '0;
      r_entry <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_units <= w_units_n;
      r_tens  <= w_tens_n;
      r_entry <= ENTRY_W'(w_tens_n) * ENTRY_W'(10) + ENTRY_W'(w_units_n);
      r_valid <= r_valid ? !i_ready : w_sub;
      if (w_sub && !r_valid) r_data <= r_entry;
      r_drop  <= w_sub & r_valid;
    end
  end
  assign o_entry = r_entry;
  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_drop  = r_drop;
endmodule

// File: tb/tb_switch_entry_ctrl.sv
// tb_switch_entry_ctrl: directed checks of debounce latency, digit entry, submit/handshake and reset
module tb_switch_entry_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] sw = '0;
  logic ready = 1'b0;
  logic [7:0] entry, data;
  logic valid, drop;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  switch_entry_ctrl #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(20)) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Switch_1 (sw[0]),
    .i_Switch_2 (sw[1]),
    .i_Switch_3 (sw[2]),
    .i_Switch_4 (sw[3]),
    .o_entry    (entry),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_drop     (drop)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tap(input logic [3:0] m);
    sw = m;
    repeat (12) @(negedge clk);
    sw = '0;
    repeat (12) @(negedge clk);
  endtask
  task automatic taps(input logic [3:0] m, input int n);
    for (int k = 0; k < n; k++) tap(m);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_entry", entry, 8'd0);
    chk("rst_data", data, 8'd0);
    chk("rst_valid", {7'd0, valid}, 8'd0);
    chk("rst_drop", {7'd0, drop}, 8'd0);
    rst = 1'b0;
    // exact latency: press visible after edge 7, entry updates on edge 8
    sw = 4'b0001;
    repeat (7) @(negedge clk);
    chk("lat_before", entry, 8'd0);
    @(negedge clk);
    chk("lat_after", entry, 8'd1);
    repeat (4) @(negedge clk);
    sw = '0;
    repeat (12) @(negedge clk);
    chk("held_one_event", entry, 8'd1);
    taps(4'b0001, 2);
    taps(4'b0010, 2);
    chk("entry_23", entry, 8'd23);
    chk("valid_idle", {7'd0, valid}, 8'd0);
    taps(4'b0001, 6);
    chk("entry_29", entry, 8'd29);
    tap(4'b0001);
    chk("units_wrap", entry, 8'd20);
    tap(4'b1000);
    chk("clear", entry, 8'd0);
    for (int w = 1; w <= 3; w++) begin
      sw = 4'b0001;
      repeat (w) @(negedge clk);
      sw = '0;
      repeat (6) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("bounce_none", entry, 8'd0);
    tap(4'b0001);
    chk("bounce_then_press", entry, 8'd1);
    tap(4'b1000);
    taps(4'b0010, 4);
    taps(4'b0001, 2);
    chk("entry_42", entry, 8'd42);
    tap(4'b0100);
    chk("sub_valid", {7'd0, valid}, 8'd1);
    chk("sub_data", data, 8'd42);
    chk("sub_nodrop", {7'd0, drop}, 8'd0);
    tap(4'b1000);
    chk("clr_entry", entry, 8'd0);
    chk("clr_data_held", data, 8'd42);
    chk("clr_valid_held", {7'd0, valid}, 8'd1);
    sw = 4'b0100;
    repeat (7) @(negedge clk);
    chk("drop_before", {7'd0, drop}, 8'd0);
    @(negedge clk);
    chk("drop_pulse", {7'd0, drop}, 8'd1);
    @(negedge clk);
    chk("drop_end", {7'd0, drop}, 8'd0);
    chk("drop_data_held", data, 8'd42);
    sw = '0;
    repeat (12) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    chk("xfer_valid_low", {7'd0, valid}, 8'd0);
    ready = 1'b0;
    tap(4'b0011);
    chk("both_digits", entry, 8'd11);
    tap(4'b1100);
    chk("subclr_data", data, 8'd11);
    chk("subclr_valid", {7'd0, valid}, 8'd1);
    chk("subclr_entry", entry, 8'd0);
    sw = 4'b0001;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_entry", entry, 8'd0);
    chk("arst_data", data, 8'd0);
    chk("arst_valid", {7'd0, valid}, 8'd0);
    chk("arst_drop", {7'd0, drop}, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("held_thru_rst", entry, 8'd1);
    sw = '0;
    repeat (12) @(negedge clk);
    chk("held_thru_rst_once", entry, 8'd1);
`ifdef SWITCH_AUTOREPEAT_EN
    tap(4'b1000);
    sw = 4'b0010;
    repeat (53) @(negedge clk);
    sw = '0;
    repeat (12) @(negedge clk);
    chk("autorepeat_tens", entry, 8'd30);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
